core_inst_seq: RTL

- Instruction sequencer that autonomously generates the 34-bit `inst` word consumed by the core. It is the initiator side of the instruction interface that the testbench drives today.
- One `start` pulse runs one tile:
  - load weights xmem→L0→PE array, then drain;
  - stream activations xmem→L0 and execute;
  - write OFIFO psums into pmem.
- Sits beside `core`; `inst` and `ofifo_valid` connect directly.

---
 rtl/core_pkg.sv | 34 +++
 rtl/sram_l0_feeder.sv | 51 +++++
 rtl/core_inst_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core instruction word: field positions, idle word, sequencer states.
package core_pkg;

    localparam int INST_W       = 34;
    localparam int ACC_BIT      = 33;
    localparam int CEN_PMEM_BIT = 32;
    localparam int WEN_PMEM_BIT = 31;
    localparam int A_PMEM_LSB   = 20;
    localparam int CEN_XMEM_BIT = 19;
    localparam int WEN_XMEM_BIT = 18;
    localparam int A_XMEM_LSB   = 7;
    localparam int OFIFO_RD_BIT = 6;
    localparam int IFIFO_WR_BIT = 5;
    localparam int IFIFO_RD_BIT = 4;
    localparam int L0_RD_BIT    = 3;
    localparam int L0_WR_BIT    = 2;
    localparam int EXECUTE_BIT  = 1;
    localparam int LOAD_BIT     = 0;

    // SRAM enables are active-low, so the quiet word keeps both CEN/WEN pairs high.
    localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        IDLE,
        W_L0,
        W_LOAD,
        W_DRAIN,
        X_L0,
        EXEC,
        PSUM,
        DONE
    } state_t;

endpackage

// File: rtl/sram_l0_feeder.sv
// Issues count xmem reads from base and raises l0_wr one cycle behind each read (SRAM read latency).
// Outputs describe the NEXT cycle so the parent can register them straight into its instruction word.
module sram_l0_feeder #(
    parameter int addr_w = 11,
    parameter int len_w  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [addr_w-1:0] base,
    input  logic [len_w:0]    count,
    output logic              cen,
    output logic [addr_w-1:0] addr,
    output logic              l0_wr,
    output logic              fin
);

    localparam logic [len_w:0] K_ONE = (len_w+1)'(1);

    logic           active_q, active_d;
    logic [len_w:0] k_q, k_d;

    // Phase lasts count+1 cycles: count reads, plus one trailing l0 write.
    assign fin = active_q && (k_q == count);

    always_comb begin
        active_d = 1'b0;
        k_d      = '0;
        if (go) begin
            active_d = 1'b1;
        end else if (active_q && !fin) begin
            active_d = 1'b1;
            k_d      = k_q + K_ONE;
        end
    end

    assign cen   = !(active_d && (k_d < count));
    assign addr  = cen ? '0 : base + addr_w'(k_d);
    assign l0_wr = active_d && (k_d != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            k_q      <= '0;
        end else begin
            active_q <= active_d;
            k_q      <= k_d;
        end
    end

endmodule

// File: rtl/core_inst_seq.sv
// Tile sequencer driving the core's 34-bit inst word; all outputs registered, PSUM stalls on ofifo_valid.
// Optional CORE_INST_SEQ_ACC_EN adds acc_mode, driven onto inst[33] during psum writes.
module core_inst_seq
    import core_pkg::*;
#(
    parameter int row       = 8,
    parameter int col       = 8,
    parameter int addr_w    = 11,
    parameter int len_w     = 11,
    parameter int drain_cyc = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] w_base,
    input  logic [addr_w-1:0] x_base,
    input  logic [len_w-1:0]  x_len,
    input  logic [addr_w-1:0] p_base,
    input  logic              ofifo_valid,
`ifdef CORE_INST_SEQ_ACC_EN
    input  logic              acc_mode,
`endif
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam logic [len_w:0] K_ONE      = (len_w+1)'(1);
    localparam logic [len_w:0] ROW_CNT    = (len_w+1)'(row);
    localparam logic [len_w:0] COL_LAST   = (len_w+1)'(col - 1);
    localparam logic [len_w:0] DRAIN_LAST = (len_w+1)'(drain_cyc - 1);

    state_t            state_q, state_d;
    logic [len_w:0]    k_q, k_d, n_q, n_d, x_cnt, written;
    logic              wr_q, wr_d, go, latch;
    logic [addr_w-1:0] w_base_q, x_base_q, p_base_q;
    logic [len_w-1:0]  x_len_q;
`ifdef CORE_INST_SEQ_ACC_EN
    logic              acc_q;
`endif

    logic              feed_x, feed_cen, feed_l0_wr, fin;
    logic [addr_w-1:0] feed_base, feed_addr;
    logic [len_w:0]    feed_cnt;
    logic [INST_W-1:0] inst_d;

    assign x_cnt   = {1'b0, x_len_q};
    assign written = n_q + {{len_w{1'b0}}, wr_q};

    // Feeder parameters follow the phase being entered or run; at the start edge the bases are not latched yet.
    assign feed_x    = (state_q == W_DRAIN) || (state_q == X_L0);
    assign feed_base = feed_x ? x_base_q : ((state_q == IDLE) ? w_base : w_base_q);
    assign feed_cnt  = feed_x ? x_cnt : ROW_CNT;

    sram_l0_feeder #(
        .addr_w (addr_w),
        .len_w  (len_w)
    ) u_feeder (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .base  (feed_base),
        .count (feed_cnt),
        .cen   (feed_cen),
        .addr  (feed_addr),
        .l0_wr (feed_l0_wr),
        .fin   (fin)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        wr_d    = 1'b0;
        go      = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = W_L0;
                    go      = 1'b1;
                    latch   = 1'b1;
                end
            end
            W_L0: begin
                if (fin) begin
                    state_d = W_LOAD;
                    k_d     = '0;
                end
            end
            W_LOAD: begin
                if (k_q == COL_LAST) begin
                    state_d = W_DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + K_ONE;
                end
            end
            W_DRAIN: begin
                if (k_q == DRAIN_LAST) begin
                    k_d = '0;
                    if (x_cnt == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = X_L0;
                        go      = 1'b1;
                    end
                end else begin
                    k_d = k_q + K_ONE;
                end
            end
            X_L0: begin
                if (fin) begin
                    state_d = EXEC;
                    k_d     = '0;
                end
            end
            EXEC: begin
                if (k_q == x_cnt - K_ONE) begin
                    state_d = PSUM;
                    k_d     = '0;
                    n_d     = '0;
                    wr_d    = ofifo_valid;
                end else begin
                    k_d = k_q + K_ONE;
                end
            end
            PSUM: begin
                // n counts writes already issued; wr_q marks a write in the current cycle.
                if (written == x_cnt) begin
                    state_d = DONE;
                    n_d     = '0;
                end else begin
                    n_d  = written;
                    wr_d = ofifo_valid;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        inst_d               = IDLE_INST;
        inst_d[ACC_BIT]      = 1'b0;
        inst_d[CEN_XMEM_BIT] = feed_cen;
        inst_d[WEN_XMEM_BIT] = 1'b1;
        inst_d[A_XMEM_LSB +: addr_w] = feed_addr;
        inst_d[L0_WR_BIT]    = feed_l0_wr;
        inst_d[IFIFO_WR_BIT] = 1'b0;
        inst_d[IFIFO_RD_BIT] = 1'b0;
        case (state_d)
            W_LOAD: begin
                inst_d[L0_RD_BIT] = 1'b1;
                inst_d[LOAD_BIT]  = 1'b1;
            end
            EXEC: begin
                inst_d[L0_RD_BIT]   = 1'b1;
                inst_d[EXECUTE_BIT] = 1'b1;
            end
            PSUM: begin
                if (wr_d) begin
                    inst_d[OFIFO_RD_BIT] = 1'b1;
                    inst_d[CEN_PMEM_BIT] = 1'b0;
                    inst_d[WEN_PMEM_BIT] = 1'b0;
                    inst_d[A_PMEM_LSB +: addr_w] = p_base_q + addr_w'(n_d);
`ifdef CORE_INST_SEQ_ACC_EN
                    inst_d[ACC_BIT] = acc_q;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            n_q      <= '0;
            wr_q     <= 1'b0;
            inst     <= IDLE_INST;
            busy     <= 1'b0;
            done     <= 1'b0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            x_len_q  <= '0;
`ifdef CORE_INST_SEQ_ACC_EN
            acc_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            wr_q    <= wr_d;
            inst    <= inst_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
            if (latch) begin
                w_base_q <= w_base;
                x_base_q <= x_base;
                p_base_q <= p_base;
                x_len_q  <= x_len;
`ifdef CORE_INST_SEQ_ACC_EN
                acc_q    <= acc_mode;
`endif
            end
        end
    end

endmodule
